// File: rtl/mem_defs.sv
// Shared data-memory access encodings and byte-lane helpers.
// Also used by the controller's mem_op encoder, so keep the codes stable.
package mem_defs;

    localparam int MEM_OP_W = 3;

    localparam logic [MEM_OP_W-1:0] MEM_W  = 3'b000;
    localparam logic [MEM_OP_W-1:0] MEM_B  = 3'b001;
    localparam logic [MEM_OP_W-1:0] MEM_BU = 3'b010;
    localparam logic [MEM_OP_W-1:0] MEM_H  = 3'b011;
    localparam logic [MEM_OP_W-1:0] MEM_HU = 3'b100;

    typedef struct packed {
        logic [3:0]  mask;
        logic [31:0] data;
    } sb_lanes_t;

    function automatic logic [3:0] be_gen(input logic [MEM_OP_W-1:0] op,
                                          input logic [1:0] addr);
        case (op)
            MEM_B, MEM_BU: be_gen = 4'b0001 << addr;
            MEM_H, MEM_HU: be_gen = addr[1] ? 4'b1100 : 4'b0011;
            default:       be_gen = 4'b1111;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [MEM_OP_W-1:0] op,
                                           input logic [1:0] addr);
        case (op)
            MEM_B, MEM_BU: is_misaligned = 1'b0;
            MEM_H, MEM_HU: is_misaligned = addr[0];
            default:       is_misaligned = |addr;
        endcase
    endfunction

    function automatic logic [31:0] ld_ext(input logic [MEM_OP_W-1:0] op,
                                           input logic [1:0] addr,
                                           input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        case (addr)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = addr[1] ? word[31:16] : word[15:0];
        case (op)
            MEM_B:   ld_ext = {{24{b[7]}}, b};
            MEM_BU:  ld_ext = {24'h0, b};
            MEM_H:   ld_ext = {{16{h[15]}}, h};
            MEM_HU:  ld_ext = {16'h0, h};
            default: ld_ext = word;
        endcase
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised data RAM: asynchronous read, byte-masked synchronous write.
module dmem_array #(
    parameter int ADDR_W    = 10,
    parameter bit INIT_ZERO = 1'b1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [3:0]        wmask,
    input  logic [31:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    generate
        if (INIT_ZERO) begin : g_zero
            // Declaration initialiser only affects simulation start-up; rst never clears it.
            logic [31:0] mem_q [DEPTH] = '{default: 32'h0};

            always_ff @(posedge clk) begin
                if (we) begin
                    for (int i = 0; i < 4; i++) begin
                        if (wmask[i]) mem_q[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
                    end
                end
            end

            assign rdata = mem_q[raddr];
        end else begin : g_raw
            logic [31:0] mem_q [DEPTH];

            always_ff @(posedge clk) begin
                if (we) begin
                    for (int i = 0; i < 4; i++) begin
                        if (wmask[i]) mem_q[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
                    end
                end
            end

            assign rdata = mem_q[raddr];
        end
    endgenerate

endmodule

// File: rtl/dmem_responder.sv
// Data-port responder: one-entry store buffer in front of dmem_array,
// with same-cycle load forwarding and load extension.
module dmem_responder
    import mem_defs::*;
#(
    parameter int ADDR_W    = 10,
    parameter bit INIT_ZERO = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                memwriteM,
    input  logic                memtoregM,
    input  logic [31:0]         aluoutM,
    input  logic [31:0]         writedataM,
    input  logic [MEM_OP_W-1:0] mem_opM,
    output logic [31:0]         readdataM,
    output logic                misalignM,
    output logic                sb_validM
);

    logic              sb_valid_q, sb_valid_d;
    logic [ADDR_W-1:0] sb_idx_q, sb_idx_d;
    sb_lanes_t         sb_lanes_q, sb_lanes_d;

    logic [ADDR_W-1:0] req_idx;
    logic [1:0]        req_off;
    logic              misaligned;
    logic              capture;
    logic              hit;
    logic [31:0]       arr_rdata;
    logic [31:0]       merged;
    logic              unused_addr;

    assign req_idx     = aluoutM[ADDR_W+1:2];
    assign req_off     = aluoutM[1:0];
    assign unused_addr = ^aluoutM[31:ADDR_W+2];

    always_comb begin
        sb_valid_d = 1'b0;
        sb_idx_d   = sb_idx_q;
        sb_lanes_d = sb_lanes_q;
        misaligned = is_misaligned(mem_opM, req_off);
        capture    = memwriteM & ~misaligned;
        if (capture) begin
            sb_valid_d      = 1'b1;
            sb_idx_d        = req_idx;
            sb_lanes_d.mask = be_gen(mem_opM, req_off);
            case (mem_opM)
                MEM_B, MEM_BU: sb_lanes_d.data = {4{writedataM[7:0]}};
                MEM_H, MEM_HU: sb_lanes_d.data = {2{writedataM[15:0]}};
                default:       sb_lanes_d.data = writedataM;
            endcase
        end
    end

    // A pending entry is dropped on reset rather than drained.
    always_ff @(posedge clk) begin
        if (rst) begin
            sb_valid_q <= 1'b0;
        end else begin
            sb_valid_q <= sb_valid_d;
        end
        sb_idx_q   <= sb_idx_d;
        sb_lanes_q <= sb_lanes_d;
    end

    dmem_array #(
        .ADDR_W    (ADDR_W),
        .INIT_ZERO (INIT_ZERO)
    ) u_array (
        .clk   (clk),
        .we    (sb_valid_q & ~rst),
        .waddr (sb_idx_q),
        .wmask (sb_lanes_q.mask),
        .wdata (sb_lanes_q.data),
        .raddr (req_idx),
        .rdata (arr_rdata)
    );

    assign hit = sb_valid_q & (sb_idx_q == req_idx);

    always_comb begin
        merged = arr_rdata;
        for (int i = 0; i < 4; i++) begin
            if (hit && sb_lanes_q.mask[i]) merged[i*8 +: 8] = sb_lanes_q.data[i*8 +: 8];
        end
    end

    assign readdataM = (memtoregM & ~rst & ~misaligned) ? ld_ext(mem_opM, req_off, merged) : 32'h0;
    assign misalignM = ~rst & (memwriteM | memtoregM) & misaligned;
    assign sb_validM = ~rst & sb_valid_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: byte-addressed program-order memory model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        memwriteM, memtoregM;
    logic [31:0] aluoutM, writedataM;
    logic [2:0]  mem_opM;
    logic [31:0] readdataM;
    logic        misalignM, sb_validM;

    int total = 0;
    int bad   = 0;

    dmem_responder #(.ADDR_W(10), .INIT_ZERO(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .memwriteM  (memwriteM),
        .memtoregM  (memtoregM),
        .aluoutM    (aluoutM),
        .writedataM (writedataM),
        .mem_opM    (mem_opM),
        .readdataM  (readdataM),
        .misalignM  (misalignM),
        .sb_validM  (sb_validM)
    );

    always #5 clk = ~clk;

    // Model: every accepted store lands immediately in a flat 4 KiB byte array.
    // The most recent store's overwritten bytes are remembered so that a reset
    // on the very next edge can undo it.
    logic [7:0] mdl_mem [4096];
    bit         pend;
    int         pend_n;
    int         pend_addr [4];
    logic [7:0] pend_old  [4];

    function automatic int acc_size(input logic [2:0] op);
        if (op == 3'd1 || op == 3'd2) return 1;
        if (op == 3'd3 || op == 3'd4) return 2;
        return 4;
    endfunction

    function automatic bit mdl_misal(input logic [2:0] op, input logic [31:0] a);
        return (a % acc_size(op)) != 0;
    endfunction

    function automatic logic [31:0] mdl_load(input logic [2:0] op, input logic [31:0] a);
        int sz = acc_size(op);
        logic [31:0] v = 32'h0;
        for (int i = 0; i < sz; i++) v = v | (32'(mdl_mem[(a + i) % 4096]) << (8 * i));
        if (op == 3'd1 && v[7])  v = v | 32'hFFFF_FF00;
        if (op == 3'd3 && v[15]) v = v | 32'hFFFF_0000;
        return v;
    endfunction

    initial begin
        for (int i = 0; i < 4096; i++) mdl_mem[i] = 8'h0;
        pend = 0;
        pend_n = 0;
    end

    always @(posedge clk) begin
        if (rst) begin
            if (pend) for (int i = 0; i < pend_n; i++) mdl_mem[pend_addr[i]] = pend_old[i];
            pend = 0;
        end else begin
            pend = 0;
            if (memwriteM && !mdl_misal(mem_opM, aluoutM)) begin
                pend_n = acc_size(mem_opM);
                for (int i = 0; i < pend_n; i++) begin
                    pend_addr[i] = (aluoutM + i) % 4096;
                    pend_old[i]  = mdl_mem[pend_addr[i]];
                    mdl_mem[pend_addr[i]] = writedataM[8*i +: 8];
                end
                pend = 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: outputs against the model on every cycle.
    always @(negedge clk) begin
        logic [31:0] e_rd;
        logic        e_mis;
        e_mis = !rst && (memwriteM || memtoregM) && mdl_misal(mem_opM, aluoutM);
        e_rd  = (!rst && memtoregM && !mdl_misal(mem_opM, aluoutM)) ? mdl_load(mem_opM, aluoutM) : 32'h0;
        check("mdl_readdata", readdataM, e_rd);
        check("mdl_misalign", {31'h0, misalignM}, {31'h0, e_mis});
        check("mdl_sb_valid", {31'h0, sb_validM}, {31'h0, pend && !rst});
    end

    task automatic step(input logic r, input logic we, input logic re,
                        input logic [31:0] a, input logic [31:0] wd, input logic [2:0] op);
        @(posedge clk);
        #1;
        rst = r; memwriteM = we; memtoregM = re;
        aluoutM = a; writedataM = wd; mem_opM = op;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; memwriteM = 1'b0; memtoregM = 1'b1;
        aluoutM = 32'h100; writedataM = 32'h0; mem_opM = 3'd0;

        step(1, 0, 1, 32'h100, 0, 3'd0);
        check("reset_readdata", readdataM, 32'h0);
        check("reset_sb_valid", {31'h0, sb_validM}, 32'h0);
        step(1, 1, 1, 32'h101, 0, 3'd0);
        check("reset_misalign", {31'h0, misalignM}, 32'h0);

        // Forwarding then array read-back.
        step(0, 1, 0, 32'h100, 32'h11223344, 3'd0);
        step(0, 0, 1, 32'h100, 0, 3'd0);
        check("lw_fwd", readdataM, 32'h11223344);
        check("lw_fwd_sbv", {31'h0, sb_validM}, 32'h1);
        step(0, 0, 0, 0, 0, 3'd0);
        step(0, 0, 1, 32'h100, 0, 3'd0);
        check("lw_array", readdataM, 32'h11223344);
        check("lw_array_sbv", {31'h0, sb_validM}, 32'h0);

        // Byte store and extension.
        step(0, 1, 0, 32'h203, 32'h80, 3'd1);
        step(0, 0, 1, 32'h203, 0, 3'd1);
        check("lb_sign", readdataM, 32'hFFFFFF80);
        step(0, 0, 1, 32'h203, 0, 3'd2);
        check("lbu_zero", readdataM, 32'h00000080);
        step(0, 0, 1, 32'h200, 0, 3'd0);
        check("lw_after_sb", readdataM, 32'h80000000);

        // Back-to-back halves into one word.
        step(0, 1, 0, 32'h300, 32'h1234AAAA, 3'd3);
        step(0, 1, 0, 32'h302, 32'h5678BBBB, 3'd4);
        step(0, 0, 1, 32'h300, 0, 3'd0);
        check("sh_pair_lw", readdataM, 32'hBBBBAAAA);
        step(0, 0, 1, 32'h302, 0, 3'd4);
        check("lhu", readdataM, 32'h0000BBBB);
        step(0, 0, 1, 32'h302, 0, 3'd3);
        check("lh_sign", readdataM, 32'hFFFFBBBB);

        // Same-word back-to-back words.
        step(0, 1, 0, 32'h40, 32'h1, 3'd0);
        step(0, 1, 0, 32'h40, 32'h2, 3'd0);
        step(0, 0, 1, 32'h40, 0, 3'd0);
        check("sw_order", readdataM, 32'h2);

        // Misalignment.
        step(0, 0, 1, 32'h101, 0, 3'd3);
        check("lh_misal_flag", {31'h0, misalignM}, 32'h1);
        check("lh_misal_data", readdataM, 32'h0);
        step(0, 1, 0, 32'h102, 32'hCAFEF00D, 3'd0);
        check("sw_misal_flag", {31'h0, misalignM}, 32'h1);
        step(0, 0, 1, 32'h100, 0, 3'd0);
        check("sw_misal_dropped", readdataM, 32'h11223344);
        check("sw_misal_sbv", {31'h0, sb_validM}, 32'h0);

        // Simultaneous load and store: load sees the old word.
        step(0, 1, 1, 32'h100, 32'h99887766, 3'd0);
        check("ld_st_same_cycle", readdataM, 32'h11223344);
        step(0, 0, 1, 32'h100, 0, 3'd0);
        check("ld_after_ld_st", readdataM, 32'h99887766);

        // Reset discards a pending store; addresses wrap at 4 KiB.
        step(0, 1, 0, 32'h500, 32'hDEADBEEF, 3'd0);
        step(1, 0, 0, 0, 0, 3'd0);
        step(0, 0, 1, 32'h500, 0, 3'd0);
        check("rst_sbv", {31'h0, sb_validM}, 32'h0);
        check("rst_discard", readdataM, 32'h0);
        step(0, 1, 0, 32'h1500, 32'h5A5A1234, 3'd0);
        step(0, 0, 1, 32'h500, 0, 3'd0);
        check("wrap", readdataM, 32'h5A5A1234);

        // Randomized traffic over a small address window to force collisions.
        for (int n = 0; n < 4000; n++) begin
            logic [31:0] a;
            a = {$urandom_range(0, 15), 12'h0} | 32'($urandom_range(0, 63)) | 32'h600;
            step($urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 2) != 0, a, $urandom, 3'($urandom_range(0, 7)));
        end
        step(0, 0, 0, 0, 0, 3'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the core's data port.
- Accepts the MEM-stage request (address, store data, mem_op, write and read strobes) and returns the extended load data in the same cycle.
- Owns a word-organised data array behind a one-entry registered store buffer. Loads merge in buffered bytes, so a load that follows a store always sees it.
- Sits beside the core at the top level, in place of an external data RAM.

Parameters:
- ADDR_W, 10, word-address width; array depth is 2**ADDR_W words (4 KiB).
- INIT_ZERO, 1, when 1 the array is cleared to zero at time 0 (simulation only, never by rst).

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- memwriteM  in  1  store request this cycle; already masked by the core on exception commit.
- memtoregM  in  1  load request this cycle.
- aluoutM  in  32  byte address.
- writedataM  in  32  store data, right-aligned.
- mem_opM  in  3  access size/extension code.
- readdataM  out  32  extended load data, combinational.
- misalignM  out  1  request address not aligned to its size; combinational.
- sb_validM  out  1  store buffer holds an undrained entry; debug.

Behaviour:
- mem_op codes:
  - 000 word.
  - 001 byte signed.
  - 010 byte unsigned.
  - 011 half signed.
  - 100 half unsigned.
  - 101..111 are treated as word.
  - Stores ignore the signedness (010 behaves as 001, 100 as 011).
- Little-endian byte lanes. Word index is aluoutM[ADDR_W+1:2]; upper address bits are ignored, so addresses wrap modulo 4 KiB.
- Alignment:
  - Half requires addr[0]=0; word requires addr[1:0]=00.
  - misalignM = (memwriteM|memtoregM) & misaligned.
  - A misaligned store is dropped and not captured.
  - A misaligned load returns 0.
- Store capture: on a rising edge with memwriteM=1, aligned, and rst=0, the buffer latches {word index, 4-bit byte mask, lane-replicated data} and sets valid.
  - SB: the low data byte is replicated to all lanes; mask = 1<<addr[1:0].
  - SH: the low half is replicated; mask = 0011 or 1100.
  - SW: mask = 1111.
- Drain: whenever valid=1 at a rising edge, the masked bytes are written to the array at that edge.
  - valid then takes the value of the new capture (1 if a store is present this cycle, else 0).
  - Back-to-back stores therefore drain one and capture the next on the same edge, with no stall and no loss.
  - Same-word back-to-back stores: the older entry drains first and the newer entry overwrites it in the following cycle; final bytes equal program order.
- Load path (combinational):
  - Read the array word asynchronously.
  - If valid and the buffer index equals the load index, substitute buffered bytes on the masked lanes.
  - Select the byte or half by addr, then sign- or zero-extend per mem_op.
  - Latency 0: data is valid in the same cycle as memtoregM.
- readdataM is 0 when memtoregM=0 or rst=1.
- Simultaneous load and store in one cycle (not issued by the core): the load sees the pre-store state; the store is captured normally.
- Reset:
  - valid <= 0; the pending entry is discarded without draining (reset mid-store loses at most the last store).
  - Array contents are preserved.
  - Outputs during reset: readdataM=0, misalignM=0, sb_validM=0.

Decomposition:
- Shared package mem_defs holds:
  - MEM_OP_W, MEM_W, MEM_B, MEM_BU, MEM_H, MEM_HU.
  - Function be_gen(op, addr[1:0]) returning the 4-bit mask.
  - Function ld_ext(op, addr[1:0], word) returning the extended data.
- The same constants are shared with the controller's mem_op encoder.
- One natural sub-module: dmem_array (async-read, byte-masked sync-write RAM, depth 2**ADDR_W).
- The buffer, forwarding and extension logic live in dmem_responder.

Test Plan:
- SW 0x11223344 @0x100; next cycle LW @0x100 -> 0x11223344 via forwarding, with sb_validM=1 during the load; LW again two cycles later -> same value from the array with sb_validM=0.
- SB 0x80 @0x203; LB @0x203 -> 0xFFFFFF80; LBU @0x203 -> 0x00000080; LW @0x200 -> bytes [23:0] unchanged from prior contents.
- Back-to-back SH 0xAAAA @0x300 then SH 0xBBBB @0x302, then LW @0x300 -> 0xBBBBAAAA; LHU @0x302 -> 0x0000BBBB.
- Back-to-back SW 1 then SW 2 to the same word @0x40; LW @0x40 -> 2.
- LH @0x101 and SW @0x102 -> misalignM=1; LH returns 0; a subsequent LW @0x100 shows the SW was dropped.
- SW @0x500 with rst asserted on the next edge -> sb_validM=0 after reset and the array word at 0x500 is unchanged; SW @0x1500 then LW @0x500 -> equal data (address wrap).
